// File: rtl/uart_rx.sv
// 8N1 UART receiver with a first-word-fall-through receive FIFO.
// Frames are sampled mid-bit using a per-bit baud divider; good bytes are queued for the bus side.
module uart_rx #(
    parameter int DEPTH = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [15:0]                baud_div_i,
    input  logic                       rx_en_i,
    input  logic                       rx_bit_i,
    input  logic                       rx_re_i,
    output logic [7:0]                 dout_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o,
    output logic                       frame_err_o,
    output logic                       overrun_o
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;

    state_t            state_r, next_state_s;
    logic              sync1_r, rxs_r, rxs_d_r;
    logic [15:0]       baud_cnt_r, div_s, half_s;
    logic [2:0]        bit_idx_r;
    logic [7:0]        shreg_r, dout_r;
    logic [7:0]        mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r, rd_ptr_r, rd_nxt_s;
    logic [LW-1:0]     level_r;
    logic              frame_err_r, overrun_r;
    logic              cnt_clr_s, shift_s, bit_clr_s, push_s, ferr_s, ovr_s;
    logic              pop_s, full_s, empty_s, can_accept_s;

    assign div_s        = (baud_div_i < 16'd2) ? 16'd2 : baud_div_i;
    assign half_s       = div_s >> 1;
    assign full_s       = (level_r == LW'(DEPTH));
    assign empty_s      = (level_r == LW'(0));
    assign pop_s        = rx_re_i && !empty_s;
    assign can_accept_s = !full_s || rx_re_i;
    assign rd_nxt_s     = rd_ptr_r + AW'(1);

    assign dout_o      = dout_r;
    assign empty_o     = empty_s;
    assign full_o      = full_s;
    assign level_o     = level_r;
    assign frame_err_o = frame_err_r;
    assign overrun_o   = overrun_r;

    // Synchronizer, edge-detect delay and FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_r <= 1'b1;
            rxs_r   <= 1'b1;
            rxs_d_r <= 1'b1;
            state_r <= IDLE;
        end else begin
            sync1_r <= rx_bit_i;
            rxs_r   <= sync1_r;
            rxs_d_r <= rxs_r;
            state_r <= next_state_s;
        end
    end

    // Next-state and per-cycle control decode; disabling the receiver aborts any frame silently
    always_comb begin
        next_state_s = state_r;
        cnt_clr_s    = 1'b0;
        shift_s      = 1'b0;
        bit_clr_s    = 1'b0;
        push_s       = 1'b0;
        ferr_s       = 1'b0;
        ovr_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (rx_en_i && rxs_d_r && !rxs_r) begin
                    next_state_s = START;
                    cnt_clr_s    = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            START: begin
                if (!rx_en_i) begin
                    next_state_s = IDLE;
                    cnt_clr_s    = 1'b1;
                end else if (baud_cnt_r == half_s - 16'd1) begin
                    cnt_clr_s    = 1'b1;
                    bit_clr_s    = 1'b1;
                    next_state_s = rxs_r ? IDLE : DATA;
                end else begin
                    next_state_s = START;
                end
            end
            DATA: begin
                if (!rx_en_i) begin
                    next_state_s = IDLE;
                    cnt_clr_s    = 1'b1;
                end else if (baud_cnt_r == div_s - 16'd1) begin
                    cnt_clr_s    = 1'b1;
                    shift_s      = 1'b1;
                    next_state_s = (bit_idx_r == 3'd7) ? STOP : DATA;
                end else begin
                    next_state_s = DATA;
                end
            end
            STOP: begin
                if (!rx_en_i) begin
                    next_state_s = IDLE;
                    cnt_clr_s    = 1'b1;
                end else if (baud_cnt_r == div_s - 16'd1) begin
                    // Leave mid-stop-bit so a back-to-back start edge is not missed
                    cnt_clr_s    = 1'b1;
                    next_state_s = IDLE;
                    if (rxs_r) begin
                        push_s = can_accept_s;
                        ovr_s  = !can_accept_s;
                    end else begin
                        ferr_s = 1'b1;
                    end
                end else begin
                    next_state_s = STOP;
                end
            end
            default: begin
                next_state_s = IDLE;
                cnt_clr_s    = 1'b1;
            end
        endcase
    end

    // Baud counter, bit index, deserializer and error pulses
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            baud_cnt_r  <= 16'd0;
            bit_idx_r   <= 3'd0;
            shreg_r     <= 8'd0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            baud_cnt_r  <= (cnt_clr_s || state_r == IDLE) ? 16'd0 : baud_cnt_r + 16'd1;
            frame_err_r <= ferr_s;
            overrun_r   <= ovr_s;
            if (bit_clr_s) begin
                bit_idx_r <= 3'd0;
            end else if (shift_s) begin
                bit_idx_r <= bit_idx_r + 3'd1;
            end
            if (shift_s) begin
                shreg_r <= {rxs_r, shreg_r[7:1]};
            end
        end
    end

    // FIFO storage; no reset needed since only occupied slots are ever read
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= shreg_r;
        end
    end

    // FIFO pointers, occupancy and registered head word (holds last value when empty)
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
            dout_r   <= 8'd0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_nxt_s;
                if (level_r > LW'(1)) begin
                    dout_r <= mem_r[rd_nxt_s];
                end else if (push_s) begin
                    dout_r <= shreg_r;
                end
            end else if (push_s && empty_s) begin
                dout_r <= shreg_r;
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table-driven frames plus hand-written corner sequences,
// with a byte scoreboard queue filled when a good frame is driven and drained on FIFO reads.
module tb_uart_rx;
    localparam int DEPTH = 32;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic [15:0]   baud_div_i = 16'd16;
    logic          rx_en_i = 1'b0;
    logic          rx_bit_i = 1'b1;
    logic          rx_re_i = 1'b0;
    logic [7:0]    dout_o;
    logic          empty_o, full_o, frame_err_o, overrun_o;
    logic [LW-1:0] level_o;

    uart_rx #(.DEPTH(DEPTH)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .baud_div_i  (baud_div_i),
        .rx_en_i     (rx_en_i),
        .rx_bit_i    (rx_bit_i),
        .rx_re_i     (rx_re_i),
        .dout_o      (dout_o),
        .empty_o     (empty_o),
        .full_o      (full_o),
        .level_o     (level_o),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_ferr;
        int         exp_level;
    } vec_t;

    vec_t       vecs [7];
    logic [7:0] sb_q [$];
    int         total = 0;
    int         bad = 0;
    int         ferr_cnt = 0;
    int         ovr_cnt = 0;
    int         ferr_base, ovr_base;

    // Count cycles each pulse is high, sampled away from the active edge
    always @(negedge clk) begin
        if (frame_err_o) ferr_cnt++;
        if (overrun_o) ovr_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int div);
        rx_bit_i = 1'b0;
        tick(div);
        for (int i = 0; i < 8; i++) begin
            rx_bit_i = d[i];
            tick(div);
        end
        rx_bit_i = stop;
        tick(div);
        rx_bit_i = 1'b1;
    endtask

    task automatic pop_check(input string name);
        logic [7:0] exp;
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
        check({name, "_nonempty"}, 32'(empty_o), 32'd0);
        check({name, "_dout"}, 32'(dout_o), 32'(exp));
        rx_re_i = 1'b1;
        tick(1);
        rx_re_i = 1'b0;
    endtask

    task automatic mark();
        ferr_base = ferr_cnt;
        ovr_base  = ovr_cnt;
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 0, 1};
        vecs[1] = '{8'h3C, 1'b0, 1, 0};
        vecs[2] = '{8'h12, 1'b1, 0, 1};
        vecs[3] = '{8'h00, 1'b1, 0, 1};
        vecs[4] = '{8'hFF, 1'b1, 0, 1};
        vecs[5] = '{8'h81, 1'b0, 1, 0};
        vecs[6] = '{8'h5A, 1'b1, 0, 1};

        tick(3);
        rst_i = 1'b0;
        tick(2);
        check("rst_empty", 32'(empty_o), 32'd1);
        check("rst_full", 32'(full_o), 32'd0);
        check("rst_level", 32'(level_o), 32'd0);
        check("rst_dout", 32'(dout_o), 32'd0);
        check("rst_ferr", 32'(frame_err_o), 32'd0);
        check("rst_ovr", 32'(overrun_o), 32'd0);

        rx_en_i = 1'b1;
        tick(4);
        for (int v = 0; v < 7; v++) begin
            mark();
            if (vecs[v].stop) sb_q.push_back(vecs[v].data);
            send_frame(vecs[v].data, vecs[v].stop, 16);
            tick(8);
            check($sformatf("vec%0d_ferr", v), 32'(ferr_cnt - ferr_base), 32'(vecs[v].exp_ferr));
            check($sformatf("vec%0d_ovr", v), 32'(ovr_cnt - ovr_base), 32'd0);
            check($sformatf("vec%0d_level", v), 32'(level_o), 32'(vecs[v].exp_level));
            if (vecs[v].exp_level == 1) pop_check($sformatf("vec%0d", v));
            check($sformatf("vec%0d_empty_after", v), 32'(empty_o), 32'd1);
        end

        // Back-to-back frames at divider 10
        baud_div_i = 16'd10;
        tick(4);
        mark();
        foreach (vecs[v]) begin
        end
        sb_q.push_back(8'h00); send_frame(8'h00, 1'b1, 10);
        sb_q.push_back(8'hFF); send_frame(8'hFF, 1'b1, 10);
        sb_q.push_back(8'h55); send_frame(8'h55, 1'b1, 10);
        sb_q.push_back(8'h80); send_frame(8'h80, 1'b1, 10);
        tick(10);
        check("b2b_level", 32'(level_o), 32'd4);
        check("b2b_errs", 32'(ferr_cnt - ferr_base + ovr_cnt - ovr_base), 32'd0);
        for (int i = 0; i < 4; i++) pop_check($sformatf("b2b%0d", i));

        // Short low glitch is rejected at the start-bit midpoint
        baud_div_i = 16'd16;
        tick(4);
        mark();
        rx_bit_i = 1'b0;
        tick(3);
        rx_bit_i = 1'b1;
        tick(40);
        check("glitch_level", 32'(level_o), 32'd0);
        check("glitch_pulses", 32'(ferr_cnt - ferr_base + ovr_cnt - ovr_base), 32'd0);

        // Receiver disabled after four data bits, then a clean frame
        rx_bit_i = 1'b0;
        tick(16);
        for (int i = 0; i < 4; i++) begin
            rx_bit_i = i[0];
            tick(16);
        end
        rx_en_i  = 1'b0;
        rx_bit_i = 1'b1;
        tick(3);
        rx_en_i = 1'b1;
        tick(200);
        check("abort_level", 32'(level_o), 32'd0);
        check("abort_pulses", 32'(ferr_cnt - ferr_base + ovr_cnt - ovr_base), 32'd0);
        sb_q.push_back(8'h3A);
        send_frame(8'h3A, 1'b1, 16);
        tick(8);
        check("abort_next_level", 32'(level_o), 32'd1);
        pop_check("abort_next");

        // Fill to full, then overrun on the 33rd frame
        mark();
        for (int i = 0; i < DEPTH; i++) begin
            sb_q.push_back(8'(i));
            send_frame(8'(i), 1'b1, 16);
        end
        tick(8);
        check("fill_full", 32'(full_o), 32'd1);
        check("fill_level", 32'(level_o), 32'(DEPTH));
        send_frame(8'd32, 1'b1, 16);
        tick(8);
        check("ovr_pulse", 32'(ovr_cnt - ovr_base), 32'd1);
        check("ovr_level", 32'(level_o), 32'(DEPTH));
        check("ovr_head", 32'(dout_o), 32'd0);

        // Pop in the STOP-sample cycle while full: push and pop both happen
        mark();
        void'(sb_q.pop_front());
        sb_q.push_back(8'h77);
        fork
            send_frame(8'h77, 1'b1, 16);
            begin
                repeat (154) @(posedge clk);
                #1 rx_re_i = 1'b1;
                @(posedge clk);
                #1 rx_re_i = 1'b0;
            end
        join
        tick(4);
        check("simul_ovr", 32'(ovr_cnt - ovr_base), 32'd0);
        check("simul_level", 32'(level_o), 32'(DEPTH));
        check("simul_head", 32'(dout_o), 32'd1);
        for (int i = 0; i < DEPTH; i++) pop_check($sformatf("drain%0d", i));
        check("drain_empty", 32'(empty_o), 32'd1);
        check("drain_hold", 32'(dout_o), 32'h77);

        // Reset in the middle of a frame with data buffered
        mark();
        sb_q.push_back(8'h66);
        send_frame(8'h66, 1'b1, 16);
        tick(4);
        check("pre_rst_level", 32'(level_o), 32'd1);
        rx_bit_i = 1'b0;
        tick(40);
        rst_i    = 1'b1;
        rx_bit_i = 1'b1;
        tick(2);
        rst_i = 1'b0;
        sb_q.delete();
        tick(1);
        check("mid_rst_empty", 32'(empty_o), 32'd1);
        check("mid_rst_full", 32'(full_o), 32'd0);
        check("mid_rst_level", 32'(level_o), 32'd0);
        check("mid_rst_dout", 32'(dout_o), 32'd0);
        tick(200);
        check("mid_rst_pulses", 32'(ferr_cnt - ferr_base + ovr_cnt - ovr_base), 32'd0);
        sb_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b1, 16);
        tick(8);
        check("post_rst_level", 32'(level_o), 32'd1);
        pop_check("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver with an integrated receive FIFO. It is the downstream partner of uart_tx and consumes the serial line that uart_tx drives. It deserializes 8N1 frames (start bit, 8 data bits LSB first, 1 stop bit) using the same per-bit baud divider as uart_tx. Valid bytes are buffered in a first-word-fall-through FIFO that the bus side reads.

Parameters:
DEPTH, 32, receive FIFO depth in bytes; power of two, ≥2.

Ports:
clk_i  input  1  system clock
rst_i  input  1  synchronous reset, active-high
baud_div_i  input  16  clock cycles per bit (same meaning as uart_tx)
rx_en_i  input  1  receiver enable
rx_bit_i  input  1  asynchronous serial input; idles high
rx_re_i  input  1  pop the FIFO head
dout_o  output  8  FIFO head byte; valid while empty_o=0
empty_o  output  1  FIFO empty
full_o  output  1  FIFO full
level_o  output  $clog2(DEPTH+1)  FIFO occupancy
frame_err_o  output  1  one-cycle pulse: stop bit sampled low
overrun_o  output  1  one-cycle pulse: good frame dropped because FIFO full

Behaviour:
- Reset (rst_i=1 on a clk_i edge):
  - state=IDLE; synchronizer flops=1; counters=0.
  - FIFO emptied: empty_o=1, full_o=0, level_o=0, dout_o=0.
  - frame_err_o=0, overrun_o=0.
  - Reset mid-frame discards the partial frame and asserts no error.
- Input path:
  - 2-flop synchronizer on rx_bit_i; all logic uses the second flop (rxs).
  - A third flop (rxs_d) is used for falling-edge detection.
- Effective divider: div = max(baud_div_i, 2); half = div>>1. baud_div_i is sampled every cycle; changing it mid-frame is undefined.
- Bit counting: baud_cnt is 16 bits and counts up each cycle while in START/DATA/STOP. It is cleared on every state transition and on every sample.
- State machine:
  - IDLE: when rx_en_i=1 and rxs_d=1 and rxs=0 → START, baud_cnt=0.
  - START: when baud_cnt==half-1, sample rxs.
    - rxs=0 → DATA, bit_idx=0.
    - rxs=1 → IDLE (glitch rejected; no error pulse).
  - DATA: when baud_cnt==div-1, shift rxs into shreg MSB with a right shift, so the first data bit ends up in bit 0.
    - bit_idx increments on each sample.
    - After the 8th sample → STOP.
  - STOP: when baud_cnt==div-1, sample rxs.
    - rxs=1 and FIFO can accept → push shreg.
    - rxs=1 and FIFO cannot accept → overrun_o=1 for one cycle; byte dropped.
    - rxs=0 → frame_err_o=1 for one cycle; byte dropped.
    - Always → IDLE. This is the mid-stop-bit return, so back-to-back frames are received.
- rx_en_i=0 in any non-IDLE state: next cycle → IDLE, partial byte discarded, no pulses. rx_en_i does not gate the FIFO read side.
- Push timing: the push occurs on the clock edge ending the STOP sample cycle.
  - Pulses also align to that edge: registered, high for the following cycle.
  - The byte appears on dout_o, and empty_o falls, on that same edge.
- FIFO:
  - First-word fall-through; dout_o is the head word.
  - rx_re_i with empty_o=1 is ignored.
  - Push and pop in the same cycle are both performed and level_o is unchanged. This holds even when full, so the FIFO "can accept" when !full_o or rx_re_i=1.
  - full_o = (level_o==DEPTH); empty_o = (level_o==0).
  - Pointers wrap modulo DEPTH.
  - dout_o holds its last value when the FIFO is empty.

Test Plan:
- Basic receive: baud_div=16, drive the 0xA5 frame (bit period 16 cycles) → one push; dout_o=0xA5, level_o=1, no error pulses; rx_re_i for 1 cycle → empty_o=1.
- Loopback: uart_tx→uart_rx with baud_div=10, both enabled, bytes 0x00, 0xFF, 0x55, 0x80 back-to-back → all four received in order; no frame_err_o/overrun_o.
- Frame error: drive 0x3C with the stop bit low → frame_err_o pulses exactly once; FIFO stays empty. A following valid 0x12 frame is received correctly.
- Overrun: DEPTH=32, send 33 frames with no reads → full_o=1 after 32; the 33rd produces one overrun_o pulse. The pops then return the first 32 bytes in order (0..31 pattern).
- Glitch/abort:
  - 3-cycle low pulse at baud_div=16 → returns to IDLE, no push, no pulse.
  - rx_en_i dropped after 4 data bits → no push; the next full frame decodes correctly.
  - rst_i mid-frame → all outputs return to reset values.
- Simultaneous push/pop on full: with the FIFO full and rx_re_i asserted in the STOP-sample cycle → no overrun_o, level_o stays 32, head advances.
